// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG MCU scheduler: format codes, component
// ids, Huffman table-class codes, scheduler state encoding and the number
// of 8x8 blocks that make up one MCU for each sampling format.
package jpeg_pkg;

  localparam logic [1:0] FMT_GRAY = 2'd0;
  localparam logic [1:0] FMT_444  = 2'd1;
  localparam logic [1:0] FMT_422  = 2'd2;
  localparam logic [1:0] FMT_420  = 2'd3;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  localparam logic CLASS_DC = 1'b0;
  localparam logic CLASS_AC = 1'b1;

  localparam logic TBL_LUMA   = 1'b0;
  localparam logic TBL_CHROMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RST_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  function automatic logic [2:0] blocks_per_mcu(input logic [1:0] fmt);
    logic [2:0] n;
    case (fmt)
      FMT_GRAY: n = 3'd1;
      FMT_444:  n = 3'd3;
      FMT_422:  n = 3'd4;
      FMT_420:  n = 3'd6;
      default:  n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jpeg_mcu_layout.sv
// Combinational MCU layout table: maps (format, block position) to the
// colour component, the Huffman table id and a last-block-of-MCU flag.
module jpeg_mcu_layout
  import jpeg_pkg::*;
(
  input  logic [1:0] i_format,
  input  logic [2:0] i_blk,
  output logic [1:0] o_comp_id,
  output logic       o_tbl_id,
  output logic       o_last_blk
);

  // Luma blocks come first in every MCU, followed by one Cb and one Cr block.
  always_comb begin
    o_comp_id = COMP_Y;
    case (i_format)
      FMT_444: begin
        if (i_blk == 3'd1) o_comp_id = COMP_CB;
        else if (i_blk == 3'd2) o_comp_id = COMP_CR;
      end
      FMT_422: begin
        if (i_blk == 3'd2) o_comp_id = COMP_CB;
        else if (i_blk == 3'd3) o_comp_id = COMP_CR;
      end
      FMT_420: begin
        if (i_blk == 3'd4) o_comp_id = COMP_CB;
        else if (i_blk == 3'd5) o_comp_id = COMP_CR;
      end
      default: o_comp_id = COMP_Y;
    endcase
  end

  assign o_tbl_id   = (o_comp_id == COMP_Y) ? TBL_LUMA : TBL_CHROMA;
  assign o_last_blk = (i_blk == (blocks_per_mcu(i_format) - 3'd1));

endmodule

// File: rtl/jpeg_mcu_scheduler.sv
// JPEG MCU scheduler: walks the blocks of each MCU, selects DC/AC Huffman
// tables, counts MCUs per frame and, when JPEG_RESTART_EN is defined,
// pauses for RSTn markers every cfg_rst_interval MCUs.
module jpeg_mcu_scheduler
  import jpeg_pkg::*;
#(
  parameter int MCU_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_format,
  input  logic [MCU_W-1:0] cfg_mcu_total,
  input  logic [MCU_W-1:0] cfg_rst_interval,
  input  logic             coeff_valid,
  input  logic [5:0]       coeff_index,
  input  logic             block_done,
  input  logic             rst_marker_done,
  output logic             dec_enable,
  output logic [1:0]       comp_id,
  output logic [2:0]       blk_in_mcu,
  output logic [1:0]       huff_tbl_sel,
  output logic             dc_reset,
  output logic             mcu_done,
  output logic             frame_done,
  output logic             restart_req,
  output logic             busy,
  output logic [MCU_W-1:0] mcu_count
);

  localparam logic [MCU_W-1:0] ONE = {{(MCU_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_format;
  logic [MCU_W-1:0] r_total;
  logic [2:0]       r_blk;
  logic             r_class;
  logic [MCU_W-1:0] r_mcu_count;
  logic             r_dc_reset;
  logic             r_mcu_done;
  logic [1:0]       w_comp_id;
  logic             w_tbl_id;
  logic             w_last_blk;
  logic [MCU_W-1:0] w_count_inc;
  logic             w_frame_end;

  jpeg_mcu_layout u_layout (
    .i_format   (r_format),
    .i_blk      (r_blk),
    .o_comp_id  (w_comp_id),
    .o_tbl_id   (w_tbl_id),
    .o_last_blk (w_last_blk)
  );

  assign w_count_inc = r_mcu_count + ONE;
  assign w_frame_end = (w_count_inc == r_total);

`ifdef JPEG_RESTART_EN
  logic [MCU_W-1:0] r_interval;
  logic [MCU_W-1:0] r_intv_count;
  logic [MCU_W-1:0] w_intv_inc;
  logic             w_intv_end;

  assign w_intv_inc = r_intv_count + ONE;
  assign w_intv_end = (r_interval != '0) && (w_intv_inc == r_interval);
`else
  logic w_unused;
  assign w_unused = ^{cfg_rst_interval, rst_marker_done};
`endif

  // State register; abort is folded into the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state: the final MCU of a frame always wins over a restart pause.
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (start) w_state_next = ST_RUN;
        ST_RUN: begin
          if (block_done && w_last_blk) begin
            if (w_frame_end) w_state_next = ST_DONE;
`ifdef JPEG_RESTART_EN
            else if (w_intv_end) w_state_next = ST_RST_WAIT;
`endif
          end
        end
`ifdef JPEG_RESTART_EN
        ST_RST_WAIT: if (rst_marker_done) w_state_next = ST_RUN;
`endif
        ST_DONE: w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Config latch, block/MCU counters, table class and one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_format    <= FMT_GRAY;
      r_total     <= '0;
      r_blk       <= '0;
      r_class     <= CLASS_DC;
      r_mcu_count <= '0;
      r_dc_reset  <= 1'b0;
      r_mcu_done  <= 1'b0;
`ifdef JPEG_RESTART_EN
      r_interval   <= '0;
      r_intv_count <= '0;
`endif
    end else if (abort) begin
      r_format    <= FMT_GRAY;
      r_total     <= '0;
      r_blk       <= '0;
      r_class     <= CLASS_DC;
      r_mcu_count <= '0;
      r_dc_reset  <= 1'b0;
      r_mcu_done  <= 1'b0;
`ifdef JPEG_RESTART_EN
      r_interval   <= '0;
      r_intv_count <= '0;
`endif
    end else begin
      r_dc_reset <= 1'b0;
      r_mcu_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_format    <= cfg_format;
            r_total     <= (cfg_mcu_total == '0) ? ONE : cfg_mcu_total;
            r_blk       <= '0;
            r_class     <= CLASS_DC;
            r_mcu_count <= '0;
            r_dc_reset  <= 1'b1;
`ifdef JPEG_RESTART_EN
            r_interval   <= cfg_rst_interval;
            r_intv_count <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (block_done) begin
            r_class <= CLASS_DC;
            if (w_last_blk) begin
              r_blk       <= '0;
              r_mcu_count <= w_count_inc;
              r_mcu_done  <= 1'b1;
`ifdef JPEG_RESTART_EN
              r_intv_count <= w_intv_inc;
`endif
            end else begin
              r_blk <= r_blk + 3'd1;
            end
          end else if (coeff_valid && (coeff_index == 6'd0)) begin
            r_class <= CLASS_AC;
          end
        end
`ifdef JPEG_RESTART_EN
        ST_RST_WAIT: begin
          if (rst_marker_done) begin
            r_dc_reset   <= 1'b1;
            r_intv_count <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign dec_enable   = (r_state == ST_RUN);
  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = (r_state == ST_DONE);
`ifdef JPEG_RESTART_EN
  assign restart_req  = (r_state == ST_RST_WAIT);
`else
  assign restart_req  = 1'b0;
`endif
  assign comp_id      = w_comp_id;
  assign blk_in_mcu   = r_blk;
  assign huff_tbl_sel = {r_class, w_tbl_id};
  assign dc_reset     = r_dc_reset;
  assign mcu_done     = r_mcu_done;
  assign mcu_count    = r_mcu_count;

endmodule
